// File: rtl/abr_prim_arbiter_wrr.sv
`default_nettype none
// ============================================================================
// Module   : abr_prim_arbiter_wrr
// Brief    : N:1 weighted round-robin arbiter; a winner keeps the grant for
//            up to weight_i[j]+1 accepted transfers, decision locked on stall.
// Revision : 1.0 - initial release
// ============================================================================
module abr_prim_arbiter_wrr #(
  parameter int N          = 8,
  parameter int DW         = 32,
  parameter int WW         = 4,
  parameter bit EnDataPort = 1'b1,
  localparam int IdxW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_chk_i,
  input  logic [N-1:0]           req_i,
  input  logic [N-1:0][WW-1:0]   weight_i,
  input  logic [N-1:0][DW-1:0]   data_i,
  output logic [N-1:0]           gnt_o,
  output logic [IdxW-1:0]        idx_o,
  output logic                   valid_o,
  output logic [DW-1:0]          data_o,
  output logic                   last_o,
  input  logic                   ready_i
);

  if (N == 1) begin : g_single
    logic w_unused_single;
    assign w_unused_single = ^{clk_i, rst_i, req_chk_i, weight_i};
    assign valid_o = req_i[0];
    assign gnt_o   = req_i[0] & ready_i;
    assign idx_o   = '0;
    assign last_o  = req_i[0];
    assign data_o  = EnDataPort ? (req_i[0] ? data_i[0] : '0) : '1;
  end else begin : g_multi
    logic [IdxW-1:0] r_cur;
    logic [WW-1:0]   r_cnt;
    logic            r_own;
    logic            r_hold;
    logic            r_hnew;

    logic            w_valid;
    logic            w_hold_win;
    logic            w_burst_win;
    logic            w_new;
    logic            w_hi_vld;
    logic [IdxW-1:0] w_hi;
    logic [IdxW-1:0] w_lo;
    logic [IdxW-1:0] w_idx;
    logic            w_last;

    always_comb begin
      w_valid     = |req_i;
      w_hold_win  = r_hold & req_i[r_cur];
      w_burst_win = r_own & req_i[r_cur] & (r_cnt != '0);
      w_hi_vld    = 1'b0;
      w_hi        = '0;
      w_lo        = '0;
      // Descending scan: the last hit is the lowest index in each class.
      for (int j = N - 1; j >= 0; j--) begin
        if (req_i[j]) begin
          w_lo = IdxW'(j);
          if (j > int'(r_cur)) begin
            w_hi     = IdxW'(j);
            w_hi_vld = 1'b1;
          end
        end
      end
      if (w_hold_win || w_burst_win) begin
        w_idx = r_cur;
      end else begin
        w_idx = w_hi_vld ? w_hi : w_lo;
      end
      // A held new pick still owes its credit load on the eventual accept.
      w_new  = w_hold_win ? r_hnew : ~w_burst_win;
      w_last = w_valid & (w_new ? (weight_i[w_idx] == '0) : (r_cnt <= WW'(1)));
    end

    assign valid_o = w_valid;
    assign idx_o   = w_idx;
    assign last_o  = w_last;
    assign gnt_o   = (w_valid & ready_i & ~rst_i) ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;
    assign data_o  = EnDataPort ? (w_valid ? data_i[w_idx] : '0) : '1;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_cur  <= IdxW'(N - 1);
        r_cnt  <= '0;
        r_own  <= 1'b0;
        r_hold <= 1'b0;
        r_hnew <= 1'b0;
      end else if (w_valid && ready_i) begin
        r_hold <= 1'b0;
        r_hnew <= 1'b0;
        r_cur  <= w_idx;
        if (w_new) begin
          r_cnt <= weight_i[w_idx];
          r_own <= (weight_i[w_idx] != '0);
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - WW'(1);
          r_own <= (r_cnt != WW'(1));
        end else begin
          r_own <= 1'b0;
        end
      end else if (w_valid) begin
        r_hold <= 1'b1;
        r_hnew <= w_new;
        r_cur  <= w_idx;
      end else begin
        r_hold <= 1'b0;
        r_hnew <= 1'b0;
        r_own  <= 1'b0;
      end
    end

    a_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
    a_gnt_ok : assert property (@(posedge clk_i) disable iff (rst_i)
                                (gnt_o != '0) |-> (ready_i && valid_o && gnt_o[idx_o]));
    a_data   : assert property (@(posedge clk_i) disable iff (rst_i)
                                valid_o |-> (data_o == (EnDataPort ? data_i[idx_o] : '1)));
    a_lock   : assert property (@(posedge clk_i) disable iff (rst_i)
                                (req_chk_i && valid_o && !ready_i) |=>
                                ((idx_o == $past(idx_o)) || !req_i[$past(idx_o)]));
    // A burst that has credit left must continue while the owner still requests.
    a_burst  : assert property (@(posedge clk_i) disable iff (rst_i)
                                (valid_o && ready_i && !last_o) |=>
                                ((idx_o == $past(idx_o)) || !req_i[$past(idx_o)]));
  end

endmodule
`default_nettype wire
